// File: rtl/fp_mag_arbiter.sv
// Round-robin arbiter and result buffer in front of the FMIN/FMAX magnitude unit.
// Latency: accept at edge N, result pushed at edge N+1, res_valid_o visible after N+1 (2 cycles).
// Backpressure: unit clock-enable uses registered state only; up to 3 ops outstanding (s1 + 2 FIFO).

package fp_mag_arbiter_pkg;
  typedef logic [31:0] float_t;
  typedef enum logic {FMIN_ = 1'b0, FMAX_ = 1'b1} fcmp_ops;
endpackage

module fp_mag_arbiter
  import fp_mag_arbiter_pkg::*;
#(
  parameter int TAG_W      = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             req0_valid_i,
  input  logic             req1_valid_i,
  output logic             req0_ready_o,
  output logic             req1_ready_o,
  input  float_t           req0_a_i,
  input  float_t           req0_b_i,
  input  float_t           req1_a_i,
  input  float_t           req1_b_i,
  input  fcmp_ops          req0_op_i,
  input  fcmp_ops          req1_op_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output float_t           unit_a_o,
  output float_t           unit_b_o,
  output fcmp_ops          unit_op_o,
  output logic             unit_clk_en_o,
  input  float_t           unit_res_i,
  input  logic             unit_inv_i,
  input  logic             unit_ovf_i,
  input  logic             unit_unf_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output float_t           res_o,
  output logic [2:0]       res_flags_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic             res_id_o,
  output logic             busy_o
);

  localparam logic [1:0] LP_FULL = 2'(FIFO_DEPTH);

  // Op currently held in the unit's internal operand register
  logic             r_s1_v;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_id;

  // Two-entry result buffer
  float_t           r_fifo_res   [2];
  logic [2:0]       r_fifo_flags [2];
  logic [TAG_W-1:0] r_fifo_tag   [2];
  logic             r_fifo_id    [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_rr_ptr;

  logic w_full, w_adv, w_gnt0, w_gnt1, w_accept, w_push, w_pop;

  // Unit advances unless s1 is occupied and the buffer cannot take it; no downstream-ready path
  always_comb begin
    w_full        = (r_count == LP_FULL);
    unit_clk_en_o = !r_s1_v || !w_full;
    w_adv         = unit_clk_en_o && !flush_i;
    // Tie goes to r_rr_ptr; a lone requester always wins
    w_gnt0        = req0_valid_i && (!req1_valid_i || !r_rr_ptr);
    w_gnt1        = req1_valid_i && (!req0_valid_i ||  r_rr_ptr);
    req0_ready_o  = w_gnt0 && w_adv;
    req1_ready_o  = w_gnt1 && w_adv;
    w_accept      = req0_ready_o || req1_ready_o;
    // Port 0 drives the unit when idle since the unit loads on every enabled edge
    unit_a_o      = w_gnt1 ? req1_a_i  : req0_a_i;
    unit_b_o      = w_gnt1 ? req1_b_i  : req0_b_i;
    unit_op_o     = w_gnt1 ? req1_op_i : req0_op_i;
    w_push        = r_s1_v && !w_full;
    res_valid_o   = (r_count != 2'd0);
    w_pop         = res_valid_o && res_ready_i;
    res_o         = r_fifo_res[r_rd_ptr];
    res_flags_o   = r_fifo_flags[r_rd_ptr];
    res_tag_o     = r_fifo_tag[r_rd_ptr];
    res_id_o      = r_fifo_id[r_rd_ptr];
    busy_o        = r_s1_v || (r_count != 2'd0);
  end

  // Control state: s1 tracking, buffer pointers/occupancy, round-robin pointer
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_v   <= 1'b0;
      r_s1_tag <= '0;
      r_s1_id  <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_rr_ptr <= 1'b0;
    end else if (flush_i) begin
      r_s1_v   <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (unit_clk_en_o) begin
        r_s1_v   <= w_accept;
        r_s1_tag <= w_gnt1 ? req1_tag_i : req0_tag_i;
        r_s1_id  <= w_gnt1;
      end
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (req0_valid_i && req1_valid_i && w_accept) r_rr_ptr <= ~r_rr_ptr;
    end
  end

  // Buffer storage: capture unit result and flags alongside the s1 tag/id
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_res[i]   <= '0;
        r_fifo_flags[i] <= '0;
        r_fifo_tag[i]   <= '0;
        r_fifo_id[i]    <= 1'b0;
      end
    end else if (w_push && !flush_i) begin
      r_fifo_res[r_wr_ptr]   <= unit_res_i;
      r_fifo_flags[r_wr_ptr] <= {unit_inv_i, unit_ovf_i, unit_unf_i};
      r_fifo_tag[r_wr_ptr]   <= r_s1_tag;
      r_fifo_id[r_wr_ptr]    <= r_s1_id;
    end
  end

endmodule

// File: tb/tb_fp_mag_arbiter.sv
// Bench for fp_mag_arbiter with a behavioural FMIN/FMAX unit stub and a queue-based scoreboard.
// Directed table vectors, hand sequences for tie/backpressure/flush/reset, then random traffic.
// Expected values come from the op queue model: a unit accepts while fewer than 3 ops are outstanding.

module tb_fp_mag_arbiter;
  import fp_mag_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic flush, v0, v1, rdy0, rdy1, clk_en, unit_inv, res_vld, res_rdy, res_id, busy;
  float_t a0, b0, a1, b1, ua, ub, unit_res, res;
  fcmp_ops o0, o1, uop;
  logic [4:0] t0, t1, res_tag;
  logic [2:0] res_flags;

  fp_mag_arbiter #(.TAG_W(5), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .req0_valid_i(v0), .req1_valid_i(v1), .req0_ready_o(rdy0), .req1_ready_o(rdy1),
    .req0_a_i(a0), .req0_b_i(b0), .req1_a_i(a1), .req1_b_i(b1),
    .req0_op_i(o0), .req1_op_i(o1), .req0_tag_i(t0), .req1_tag_i(t1),
    .unit_a_o(ua), .unit_b_o(ub), .unit_op_o(uop), .unit_clk_en_o(clk_en),
    .unit_res_i(unit_res), .unit_inv_i(unit_inv), .unit_ovf_i(1'b0), .unit_unf_i(1'b0),
    .res_valid_o(res_vld), .res_ready_i(res_rdy), .res_o(res), .res_flags_o(res_flags),
    .res_tag_o(res_tag), .res_id_o(res_id), .busy_o(busy)
  );

  // IEEE minNum/maxNum: a single NaN yields the other operand, sNaN raises invalid
  function automatic logic [32:0] fminmax(input float_t a, input float_t b, input fcmp_ops op);
    bit na, nb, inv, a_lt;
    float_t r;
    na  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    inv = (na && !a[22]) || (nb && !b[22]);
    if (a[31] != b[31]) a_lt = a[31];
    else if (!a[31])    a_lt = a[30:0] < b[30:0];
    else                a_lt = a[30:0] > b[30:0];
    if (na && nb)       r = 32'h7FC00000;
    else if (na)        r = b;
    else if (nb)        r = a;
    else if (op == FMIN_) r = a_lt ? a : b;
    else                r = a_lt ? b : a;
    return {inv, r};
  endfunction

  // Unit stub: operand register loaded on clk_en, result combinational from it
  float_t  s_a, s_b;
  fcmp_ops s_op;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_a <= '0; s_b <= '0; s_op <= FMIN_;
    end else if (clk_en) begin
      s_a <= ua; s_b <= ub; s_op <= uop;
    end
  end
  assign {unit_inv, unit_res} = fminmax(s_a, s_b, s_op);

  // Scoreboard: every outstanding op in accept order; in_fifo marks ops already buffered
  typedef struct { float_t res; logic [2:0] flags; logic [4:0] tag; logic id; bit in_fifo; } ent_t;
  ent_t q[$];
  bit   m_rr;
  int   n_vec = 0;
  int   n_bad = 0;

  bit   s_acc, s_pop, s_fl, s_both;
  ent_t s_ent;
  logic a_r0, a_r1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check outputs against the model
  task automatic cyc(input bit iv0, input bit iv1, input float_t ia0, input float_t ib0,
                     input fcmp_ops io0, input logic [4:0] it0, input float_t ia1,
                     input float_t ib1, input fcmp_ops io1, input logic [4:0] it1,
                     input bit rdy, input bit fl);
    bit e_en, adv, g0, g1, e_vld;
    logic [32:0] r;
    @(negedge clk);
    v0 = iv0; v1 = iv1; a0 = ia0; b0 = ib0; o0 = io0; t0 = it0;
    a1 = ia1; b1 = ib1; o1 = io1; t1 = it1; res_rdy = rdy; flush = fl;
    #1;
    e_en  = q.size() < 3;
    adv   = e_en && !fl;
    g0    = iv0 && (!iv1 || !m_rr);
    g1    = iv1 && (!iv0 ||  m_rr);
    e_vld = (q.size() > 0) && q[0].in_fifo;
    a_r0 = rdy0; a_r1 = rdy1;
    chk("req0_ready", 32'(rdy0), 32'(g0 && adv));
    chk("req1_ready", 32'(rdy1), 32'(g1 && adv));
    chk("clk_en", 32'(clk_en), 32'(e_en));
    chk("res_valid", 32'(res_vld), 32'(e_vld));
    chk("busy", 32'(busy), 32'(q.size() > 0));
    if (e_vld) begin
      chk("res", res, q[0].res);
      chk("flags", 32'(res_flags), 32'(q[0].flags));
      chk("tag", 32'(res_tag), 32'(q[0].tag));
      chk("id", 32'(res_id), 32'(q[0].id));
    end
    if (adv && (g0 || g1)) chk("unit_a", ua, g1 ? ia1 : ia0);
    s_acc  = adv && (g0 || g1);
    s_pop  = e_vld && rdy;
    s_fl   = fl;
    s_both = iv0 && iv1;
    r = g1 ? fminmax(ia1, ib1, io1) : fminmax(ia0, ib0, io0);
    s_ent  = '{res: r[31:0], flags: {r[32], 2'b00}, tag: g1 ? it1 : it0, id: g1, in_fifo: 1'b0};
  endtask

  // Apply the clock edge to the model
  task automatic advance();
    int nf;
    @(posedge clk);
    if (s_fl) q.delete();
    else begin
      nf = 0;
      foreach (q[i]) if (q[i].in_fifo) nf++;
      foreach (q[i]) if (!q[i].in_fifo && nf < 2) q[i].in_fifo = 1'b1;
      if (s_pop) void'(q.pop_front());
      if (s_acc) q.push_back(s_ent);
      if (s_both && s_acc) m_rr = ~m_rr;
    end
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, 0, 0, FMIN_, 0, 0, 0, FMIN_, 0, rdy, 0);
    advance();
  endtask

  function automatic float_t pick();
    case ($urandom_range(0, 7))
      0: return 32'h3F800000;
      1: return 32'h40000000;
      2: return 32'hBF800000;
      3: return 32'h7F800001;
      4: return 32'h7FC00000;
      5: return 32'h00000000;
      6: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  typedef struct { float_t a; float_t b; fcmp_ops op; logic [4:0] tag; float_t exp_res; logic [2:0] exp_flags; } vec_t;
  vec_t tbl[5];
  int   acc;

  initial begin
    tbl[0] = '{32'h3F800000, 32'h40000000, FMAX_, 5'd3,  32'h40000000, 3'b000};
    tbl[1] = '{32'h7F800001, 32'h3F800000, FMIN_, 5'd7,  32'h3F800000, 3'b100};
    tbl[2] = '{32'hBF800000, 32'h3F800000, FMIN_, 5'd12, 32'hBF800000, 3'b000};
    tbl[3] = '{32'h7FC00000, 32'h40000000, FMAX_, 5'd21, 32'h40000000, 3'b000};
    tbl[4] = '{32'h80000000, 32'h00000000, FMAX_, 5'd31, 32'h00000000, 3'b000};

    v0 = 0; v1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; o0 = FMIN_; o1 = FMIN_;
    t0 = 0; t1 = 0; res_rdy = 0; flush = 0; m_rr = 0;
    #12;
    chk("rst_res_valid", 32'(res_vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clk_en", 32'(clk_en), 1);
    chk("rst_res", res, 0);
    chk("rst_flags", 32'(res_flags), 0);
    chk("rst_tag", 32'(res_tag), 0);
    chk("rst_id", 32'(res_id), 0);
    #11 rst_n = 1'b1;

    // Single-op vectors on port 0: accept, push, then result visible two cycles after accept
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].tag, 0, 0, FMIN_, 0, 1, 0);
      chk("tbl_accept", 32'(a_r0), 1);
      advance();
      idle(1);
      cyc(0, 0, 0, 0, FMIN_, 0, 0, 0, FMIN_, 0, 1, 0);
      chk("tbl_valid", 32'(res_vld), 1);
      chk("tbl_res", res, tbl[i].exp_res);
      chk("tbl_flags", 32'(res_flags), 32'(tbl[i].exp_flags));
      chk("tbl_tag", 32'(res_tag), 32'(tbl[i].tag));
      chk("tbl_id", 32'(res_id), 0);
      advance();
    end

    // Tie: both ports valid, grants alternate starting at port 0
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, pick(), pick(), FMAX_, 5'(i), pick(), pick(), FMIN_, 5'(i + 16), 1, 0);
      chk("tie_gnt1", 32'(a_r1), 32'(i % 2));
      chk("tie_gnt0", 32'(a_r0), 32'(1 - i % 2));
      advance();
    end
    repeat (3) idle(1);

    // Backpressure: port 1 streams with downstream stalled, exactly 3 accepts
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, FMIN_, 0, pick(), pick(), FMAX_, 5'(i + 1), 0, 0);
      acc += int'(a_r1);
      advance();
    end
    chk("bp_accepts", 32'(acc), 3);
    chk("bp_clk_en", 32'(clk_en), 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, 0, FMIN_, 0, pick(), pick(), FMIN_, 5'(i + 8), 1, 0);
      advance();
    end
    repeat (4) idle(1);

    // Flush with three ops outstanding
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, pick(), pick(), FMAX_, 5'(i), 0, 0, FMIN_, 0, 0, 0);
      advance();
    end
    cyc(1, 0, pick(), pick(), FMAX_, 5'd9, 0, 0, FMIN_, 0, 0, 1);
    chk("flush_ready", 32'(a_r0), 0);
    advance();
    cyc(0, 0, 0, 0, FMIN_, 0, 0, 0, FMIN_, 0, 1, 0);
    chk("flush_valid", 32'(res_vld), 0);
    chk("flush_busy", 32'(busy), 0);
    advance();
    cyc(1, 0, 32'h3F800000, 32'h40000000, FMIN_, 5'd10, 0, 0, FMIN_, 0, 1, 0);
    chk("post_flush_accept", 32'(a_r0), 1);
    advance();
    repeat (3) idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick(),
          fcmp_ops'(1'($urandom_range(0, 1))), 5'($urandom), pick(), pick(),
          fcmp_ops'(1'($urandom_range(0, 1))), 5'($urandom),
          $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
      advance();
    end
    repeat (4) idle(1);

    // Asynchronous reset between edges while the pipeline is full
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, pick(), pick(), FMAX_, 5'(i), pick(), pick(), FMIN_, 5'(i), 0, 0);
      advance();
    end
    v0 = 0; v1 = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(res_vld), 0);
    chk("async_rst_busy", 32'(busy), 0);
    q.delete();
    m_rr = 1'b0;
    #1 rst_n = 1'b1;
    cyc(1, 1, 32'h3F800000, 32'h40000000, FMAX_, 5'd1, 32'h40000000, 32'h3F800000, FMIN_, 5'd2, 1, 0);
    chk("rst_tie_port0", 32'(a_r0), 1);
    advance();
    repeat (3) idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
